sim_console_mon: RTL
====================

# sim_console_mon

Multi-channel simulation console and end-of-run monitor for the SoC testbench. It collects the character stream the core writes through the CSR printf port into per-channel line buffers and emits whole lines through a valid/ready output register. It also counts simulation cycles and detects the end of a run (software MENDS, ISA-test done flag, or watchdog timeout). On end of run it drains partial lines and raises a single sticky end indication that the bench uses to print its verdict and stop.

## Interface
- `CHN`, default 2: number of printf channels, 1..8.
- `LINE_LEN`, default 64: characters per line buffer.
- `PASS_DLY`, default 3: cycles from `isa_done` to the sampling of `isa_pass`.
- `TIMEOUT_CYC`, default 600000: watchdog limit in cycles.
- Derived: `CHW = (CHN>1) ? $clog2(CHN) : 1`; `PW = $clog2(LINE_LEN+1)`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `printf_valid`, in, 1: character strobe from the CSR printf write.
- `printf_ch`, in, CHW: channel index.
- `printf_data`, in, 8: ASCII character.
- `printf_ready`, out, 1: character accepted when high together with `printf_valid`.
- `mends`, in, 1: software end-of-simulation level.
- `isa_done`, in, 1: ISA test finished (x26==1).
- `isa_pass`, in, 1: ISA test result (x27==1).
- `out_valid`, out, 1: a line is held.
- `out_ready`, in, 1: consumer takes the line.
- `out_ch`, out, CHW: channel of the held line.
- `out_len`, out, PW: number of characters in the line, 1..LINE_LEN.
- `out_line`, out, LINE_LEN*8: line contents. First character at bits [LINE_LEN*8-1 -: 8], unused bytes 0.
- `cycle_cnt`, out, 64: cycles since reset release.
- `sim_end`, out, 1: end of run, sticky.
- `end_cause`, out, 2: 0 = none, 1 = mends, 2 = ISA, 3 = timeout.
- `end_pass`, out, 1: ISA verdict. Valid only when `end_cause==2`.

## Operation
- Every output resets to 0, as do all line buffers, pointers and the FSM (state RUN).
- `printf_ready = (state==RUN) && (!out_valid || out_ready)`.
- Accepted character 0x0A or 0x0D:
  - If the channel pointer is nonzero, the line is committed.
  - If the pointer is zero, the character is dropped, so `\r\n` yields exactly one line.
- Any other accepted character:
  - It is written at byte index `ptr` (MSB-first) and `ptr` increments.
  - If `ptr` reaches LINE_LEN, the line is auto-committed in the same cycle.
- Commit:
  - Loads `out_line`, `out_ch` and `out_len=ptr`, and sets `out_valid`.
  - Clears that channel's buffer and pointer.
- `out_valid` clears on `out_ready` unless a new commit loads it in the same cycle.
- `printf_ch >= CHN` is accepted and discarded.
- FSM:
  - RUN → DRAIN on a `mends` rising edge (`end_cause=1`) or on timeout (`end_cause=3`).
  - RUN → WAIT_PASS on `isa_done` (`end_cause=2`).
  - When end events coincide, priority is `isa_done` > `mends` > timeout.
  - WAIT_PASS counts PASS_DLY cycles, then samples `isa_pass` into `end_pass` and goes to DRAIN.
  - DRAIN scans channels 0..CHN-1 in ascending order. Each nonempty channel is committed when the output register is free, at most one per cycle. After the last channel and once `out_valid==0`, the FSM goes to DONE.
  - DONE: `sim_end=1`. Only reset leaves DONE.
- `cycle_cnt` increments every cycle and freezes on the cycle DONE is entered. It wraps modulo 2^64.
- `end_cause` and `end_pass` are held from capture until reset.

## Timing
- Commit to `out_valid` high: 1 cycle after the accepting edge.
- Back-to-back lines: one per cycle with `out_ready` held high.
- `mends` is edge-detected against its previous-cycle value. `mends` high out of reset counts as an edge on the first RUN cycle.
- WAIT_PASS lasts exactly PASS_DLY cycles. `isa_pass` is sampled on the final cycle.
- Minimum RUN → DONE latency with empty buffers: 1 (DRAIN) + CHN scan cycles.
- An `rst` assertion at any point, including mid-DRAIN, returns every output to 0 asynchronously.

## Configuration
- `SIM_TIMEOUT_EN` defined:
  - A watchdog fires when `cycle_cnt == TIMEOUT_CYC-1` in RUN.
  - The run ends with `end_cause=3` and `end_pass=0`.
- `SIM_TIMEOUT_EN` undefined:
  - No watchdog logic is built and `TIMEOUT_CYC` is ignored.
  - `end_cause` never takes the value 3.

## Test plan
- Ch0 "Hi\n" with `out_ready=1` → one line, `out_len=2`, `out_line` top bytes 0x48 0x69, rest 0. `\r\n` → still one line.
- 64 non-newline chars on ch1 → auto-commit with `out_len=64` and ch1 pointer back at 0. 65th char starts a new line.
- `out_ready=0` while a line is held, then a newline on another channel → `printf_ready=0` until `out_ready` pulses. Second line follows 1 cycle later.
- "ab" on ch1, "c" on ch0, then `mends` pulse → DRAIN emits ch0 "c", then ch1 "ab". `sim_end=1`, `end_cause=1`, `cycle_cnt` frozen.
- `isa_done=1`, with `isa_pass` raised 2 cycles later (PASS_DLY=3) → `end_cause=2`, `end_pass=1`. Same with `isa_pass` low → `end_pass=0`. `isa_done` and `mends` in the same cycle → `end_cause=2`.
- `SIM_TIMEOUT_EN` with TIMEOUT_CYC=100 and no stimulus → `end_cause=3` at `cycle_cnt==99`. Reset asserted mid-DRAIN → all outputs 0.

Source files
------------

// File: rtl/sim_console_mon.sv
// Simulation console: per-channel printf line buffers feeding one valid/ready line register,
// plus cycle counter and end-of-run detection with partial-line drain. SIM_TIMEOUT_EN builds the watchdog.
module sim_console_mon #(
  parameter int CHN         = 2,
  parameter int LINE_LEN    = 64,
  parameter int PASS_DLY    = 3,
  parameter int TIMEOUT_CYC = 600000,
  localparam int CHW = (CHN > 1) ? $clog2(CHN) : 1,
  localparam int PW  = $clog2(LINE_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  printf_valid,
  input  logic [CHW-1:0]        printf_ch,
  input  logic [7:0]            printf_data,
  output logic                  printf_ready,
  input  logic                  mends,
  input  logic                  isa_done,
  input  logic                  isa_pass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHW-1:0]        out_ch,
  output logic [PW-1:0]         out_len,
  output logic [LINE_LEN*8-1:0] out_line,
  output logic [63:0]           cycle_cnt,
  output logic                  sim_end,
  output logic [1:0]            end_cause,
  output logic                  end_pass
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam int            DLW   = (PASS_DLY > 1) ? $clog2(PASS_DLY) : 1;
  localparam logic [CHW:0]  CHN_W = (CHW+1)'(CHN);
  localparam logic [PW-1:0] LAST  = PW'(LINE_LEN - 1);

  state_t                r_state;
  logic [LINE_LEN*8-1:0] r_buf [CHN];
  logic [PW-1:0]         r_ptr [CHN];
  logic                  r_mends_q;
  logic [CHW:0]          r_scan;
  logic [DLW-1:0]        r_dly;

  logic                  w_free, w_ch_ok, w_acc, w_nl, w_wr, w_run_cm;
  logic                  w_scan_in, w_dr_cm, w_cm, w_to, w_mends_rise;
  logic [CHW-1:0]        w_ch, w_sc, w_cm_ch;
  logic [PW-1:0]         w_ptr, w_cm_len;
  logic [LINE_LEN*8-1:0] w_ins, w_cm_line;

  assign w_free       = !out_valid || out_ready;
  assign printf_ready = !rst && (r_state == S_RUN) && w_free;
  assign w_ch_ok      = {1'b0, printf_ch} < CHN_W;
  assign w_ch         = w_ch_ok ? printf_ch : '0;
  assign w_acc        = printf_valid && printf_ready && w_ch_ok;
  assign w_nl         = (printf_data == 8'h0A) || (printf_data == 8'h0D);
  assign w_ptr        = r_ptr[w_ch];
  assign w_wr         = w_acc && !w_nl;
  // Newline on an empty buffer is dropped so CR LF yields a single line.
  assign w_run_cm     = w_acc && (w_nl ? (w_ptr != '0) : (w_ptr == LAST));
  assign w_scan_in    = r_scan < CHN_W;
  assign w_sc         = w_scan_in ? r_scan[CHW-1:0] : '0;
  assign w_dr_cm      = (r_state == S_DRAIN) && w_scan_in && (r_ptr[w_sc] != '0) && w_free;
  assign w_cm         = w_run_cm || w_dr_cm;
  assign w_mends_rise = mends && !r_mends_q;

`ifdef SIM_TIMEOUT_EN
  assign w_to = (cycle_cnt == 64'(TIMEOUT_CYC - 1));
`else
  logic w_unused_to;
  assign w_unused_to = ^TIMEOUT_CYC;
  assign w_to        = 1'b0;
`endif

  always_comb begin
    w_ins = r_buf[w_ch];
    for (int b = 0; b < LINE_LEN; b++)
      if (w_ptr == PW'(b)) w_ins[(LINE_LEN-1-b)*8 +: 8] = printf_data;
  end

  // Drain and run commits never coincide: characters are only accepted in RUN.
  always_comb begin
    if (w_dr_cm) begin
      w_cm_ch   = w_sc;
      w_cm_len  = r_ptr[w_sc];
      w_cm_line = r_buf[w_sc];
    end else begin
      w_cm_ch   = w_ch;
      w_cm_len  = w_nl ? w_ptr : w_ptr + 1'b1;
      w_cm_line = w_nl ? r_buf[w_ch] : w_ins;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHN; c++) begin
        r_buf[c] <= '0;
        r_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHN; c++) begin
        if (w_cm && (w_cm_ch == CHW'(c))) begin
          r_buf[c] <= '0;
          r_ptr[c] <= '0;
        end else if (w_wr && (w_ch == CHW'(c))) begin
          r_buf[c] <= w_ins;
          r_ptr[c] <= w_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_mends_q <= 1'b0;
      r_scan    <= '0;
      r_dly     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_len   <= '0;
      out_line  <= '0;
      cycle_cnt <= '0;
      sim_end   <= 1'b0;
      end_cause <= 2'd0;
      end_pass  <= 1'b0;
    end else begin
      if (w_cm) begin
        out_valid <= 1'b1;
        out_ch    <= w_cm_ch;
        out_len   <= w_cm_len;
        out_line  <= w_cm_line;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      r_mends_q <= mends;
      if (r_state != S_DONE) cycle_cnt <= cycle_cnt + 64'd1;
      case (r_state)
        S_RUN: begin
          if (isa_done) begin
            r_state   <= S_WAIT;
            end_cause <= 2'd2;
            r_dly     <= '0;
          end else if (w_mends_rise) begin
            r_state   <= S_DRAIN;
            end_cause <= 2'd1;
            r_scan    <= '0;
          end else if (w_to) begin
            r_state   <= S_DRAIN;
            end_cause <= 2'd3;
            end_pass  <= 1'b0;
            r_scan    <= '0;
          end
        end
        S_WAIT: begin
          if (r_dly == DLW'(PASS_DLY - 1)) begin
            end_pass <= isa_pass;
            r_state  <= S_DRAIN;
            r_scan   <= '0;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_scan_in) begin
            if ((r_ptr[w_sc] == '0) || w_free) r_scan <= r_scan + 1'b1;
          end else if (!out_valid) begin
            r_state <= S_DONE;
            sim_end <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
